approx_mult_pipe_wl: RTL and testbench

//  Parametrised, 3-stage pipelined unsigned WxW approximate multiplier with runtime exact/approx mode.

---
 rtl/approx_mult_pipe_wl_if.sv | 29 ++
 rtl/approx_mult_pipe_wl.sv | 175 +++++++++++++++++
 tb/tb_approx_mult_pipe_wl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/approx_mult_pipe_wl_if.sv
// Operand/result channel of the approximate multiplier pipeline.
//   in_valid/in_ready : operand transfer handshake
//   x, y, approx      : operands and mode bit, sampled together
//   out_valid/out_ready : result transfer handshake
//   z, err_out        : product and its error distance from the exact product
// slave  = multiplier side, master = producer/consumer side.
interface approx_mult_pipe_wl_if #(
    parameter int W = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic           approx;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] z;
    logic [2*W-1:0] err_out;

    modport slave (
        input  in_valid, x, y, approx, out_ready,
        output in_ready, out_valid, z, err_out
    );

    modport master (
        output in_valid, x, y, approx, out_ready,
        input  in_ready, out_valid, z, err_out
    );
endinterface

// File: rtl/approx_mult_pipe_wl.sv
// Three-stage pipelined unsigned WxW multiplier with a runtime exact/approximate mode.
// In approximate mode rows x[W-1:L] are multiplied exactly; the low L rows are
// handled in pairs whose partial products are OR-merged, keeping only columns
// W-1 and above, and the pair vectors are then added as compensation.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   io          : operand/result handshake channel (slave modport)
//   clr_stats   : synchronous clear of max_err and approx_cnt
//   max_err     : largest err_out accepted downstream since reset/clear
//   approx_cnt  : accepted approximate results, saturating
module approx_mult_pipe_wl #(
    parameter int W   = 8,
    parameter int L   = 4,
    parameter int MON = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    approx_mult_pipe_wl_if.slave io,
    input  logic                 clr_stats,
    output logic [2*W-1:0]       max_err,
    output logic [15:0]          approx_cnt
);
    localparam int PW = 2 * W;

    // Partial-product bit of row i in column c; zero outside the row's span.
    function automatic logic pp(input logic [W-1:0] xv, input logic [W-1:0] yv,
                                input int i, input int c);
        logic [W-1:0] xs;
        logic [W-1:0] ys;
        logic         r;
        xs = xv >> i;
        ys = yv >> (c - i);
        if ((c >= i) && ((c - i) < W)) begin
            r = xs[0] & ys[0];
        end else begin
            r = 1'b0;
        end
        return r;
    endfunction

    // Exact contribution of the upper rows x[W-1:L].
    function automatic logic [PW-1:0] high_term(input logic [W-1:0] xv, input logic [W-1:0] yv);
        logic [PW-1:0] xh;
        xh = {{W{1'b0}}, xv} >> L;
        return (xh * {{W{1'b0}}, yv}) << L;
    endfunction

    // OR-merged low-row pairs; columns below W-1 are dropped entirely.
    function automatic logic [PW-1:0] comp_term(input logic [W-1:0] xv, input logic [W-1:0] yv);
        logic [PW-1:0] acc;
        logic [PW-1:0] pair;
        logic          bit_v;
        int            a;
        int            b;
        acc = {PW{1'b0}};
        for (int k = 0; k < L / 2; k++) begin
            a    = 2 * k;
            b    = a + 1;
            pair = {PW{1'b0}};
            for (int c = W - 1; c < PW; c++) begin
                if (c <= W + b) begin
                    bit_v = pp(xv, yv, a, c) | pp(xv, yv, b, c);
                end else begin
                    bit_v = 1'b0;
                end
                pair = pair | ({{(PW-1){1'b0}}, bit_v} << c);
            end
            acc = acc + pair;
        end
        return acc;
    endfunction

    logic          adv_s;
    logic          v1_r, v2_r, v3_r;
    logic          ap1_r, ap2_r, ap3_r;
    logic [W-1:0]  x1_r, y1_r;
    logic [PW-1:0] full_s, h_s, c_s, e_s;
    logic [PW-1:0] h2_r, c2_r, e2_r;
    logic [PW-1:0] zsum_s, err_s;
    logic [PW-1:0] z3_r, err3_r;
    logic [PW-1:0] max_err_r;
    logic [15:0]   approx_cnt_r;

    // Global stall: every stage moves only when the output slot can drain.
    assign adv_s       = ~v3_r | io.out_ready;
    assign io.in_ready = adv_s;
    assign io.out_valid = v3_r;
    assign io.z         = z3_r;
    assign io.err_out   = err3_r;
    assign max_err      = max_err_r;
    assign approx_cnt   = approx_cnt_r;

    assign full_s = {{W{1'b0}}, x1_r} * {{W{1'b0}}, y1_r};

    // Stage-2 terms: exact mode folds the whole product into H.
    always_comb begin
        h_s = {PW{1'b0}};
        c_s = {PW{1'b0}};
        e_s = {PW{1'b0}};
        if (ap1_r) begin
            h_s = high_term(x1_r, y1_r);
            c_s = comp_term(x1_r, y1_r);
        end else begin
            h_s = full_s;
            c_s = {PW{1'b0}};
        end
        if (MON != 0) begin
            e_s = full_s;
        end else begin
            e_s = {PW{1'b0}};
        end
    end

    // Stage-3 result and its error distance (z never exceeds the exact product).
    always_comb begin
        zsum_s = h2_r + c2_r;
        err_s  = {PW{1'b0}};
        if (MON != 0) begin
            err_s = e2_r - zsum_s;
        end else begin
            err_s = {PW{1'b0}};
        end
    end

    // Pipeline registers; the approx bit travels with its operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r   <= 1'b0;
            v2_r   <= 1'b0;
            v3_r   <= 1'b0;
            ap1_r  <= 1'b0;
            ap2_r  <= 1'b0;
            ap3_r  <= 1'b0;
            x1_r   <= {W{1'b0}};
            y1_r   <= {W{1'b0}};
            h2_r   <= {PW{1'b0}};
            c2_r   <= {PW{1'b0}};
            e2_r   <= {PW{1'b0}};
            z3_r   <= {PW{1'b0}};
            err3_r <= {PW{1'b0}};
        end else if (adv_s) begin
            v1_r   <= io.in_valid;
            ap1_r  <= io.approx;
            x1_r   <= io.x;
            y1_r   <= io.y;
            v2_r   <= v1_r;
            ap2_r  <= ap1_r;
            h2_r   <= h_s;
            c2_r   <= c_s;
            e2_r   <= e_s;
            v3_r   <= v2_r;
            ap3_r  <= ap2_r;
            z3_r   <= zsum_s;
            err3_r <= err_s;
        end
    end

    // Statistics on accepted results; a clear in the same cycle suppresses the update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_err_r    <= {PW{1'b0}};
            approx_cnt_r <= 16'h0000;
        end else if (clr_stats) begin
            max_err_r    <= {PW{1'b0}};
            approx_cnt_r <= 16'h0000;
        end else if (v3_r && io.out_ready) begin
            if (ap3_r && (approx_cnt_r != 16'hFFFF)) begin
                approx_cnt_r <= approx_cnt_r + 16'h0001;
            end
            if (err3_r > max_err_r) begin
                max_err_r <= err3_r;
            end
        end
    end
endmodule

// File: tb/tb_approx_mult_pipe_wl.sv
module tb_approx_mult_pipe_wl;
    localparam int W  = 8;
    localparam int NI = 4;
    localparam int MI = 2;   // instance with L=4 carries the literal checks

    typedef struct {
        int x;
        int y;
        bit ap;
    } op_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       approx = 1'b0;
    logic       out_ready = 1'b1;
    logic       clr_stats = 1'b0;
    logic [7:0] x = 8'h00;
    logic [7:0] y = 8'h00;

    logic [15:0] z_a   [NI];
    logic [15:0] err_a [NI];
    logic [15:0] max_a [NI];
    logic [15:0] cnt_a [NI];
    logic        ov_a  [NI];
    logic        ir_a  [NI];

    int  checks = 0;
    int  failures = 0;
    op_t sb[$];
    int  exp_max [NI];
    int  exp_cnt = 0;
    int  prev_z [NI];
    bit  prev_stall = 1'b0;
    int  out_xfers = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LG = (g == 0) ? 0 : (g == 1) ? 2 : (g == 2) ? 4 : 8;
        approx_mult_pipe_wl_if #(.W(W)) bus ();
        assign bus.in_valid  = in_valid;
        assign bus.x         = x;
        assign bus.y         = y;
        assign bus.approx    = approx;
        assign bus.out_ready = out_ready;
        approx_mult_pipe_wl #(.W(W), .L(LG), .MON(1)) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .io         (bus),
            .clr_stats  (clr_stats),
            .max_err    (max_a[g]),
            .approx_cnt (cnt_a[g])
        );
        assign z_a[g]   = bus.z;
        assign err_a[g] = bus.err_out;
        assign ov_a[g]  = bus.out_valid;
        assign ir_a[g]  = bus.in_ready;
    end

    function automatic int l_of(input int i);
        return (i == 0) ? 0 : (i == 1) ? 2 : (i == 2) ? 4 : 8;
    endfunction

    // Reference: upper rows added exactly, low rows merged two at a time by OR
    // of their shifted row vectors, masked to columns W-1 and above.
    function automatic int model_z(input int xv, input int yv, input bit ap, input int l);
        int zz;
        int ra;
        int rb;
        if (!ap || l == 0) return xv * yv;
        zz = 0;
        for (int i = l; i < W; i++)
            if (((xv >> i) & 1) != 0) zz += yv << i;
        for (int a = 0; a < l; a += 2) begin
            ra = (((xv >> a) & 1) != 0) ? (yv << a) : 0;
            rb = (((xv >> (a + 1)) & 1) != 0) ? (yv << (a + 1)) : 0;
            zz += (ra | rb) & ~((1 << (W - 1)) - 1);
        end
        return zz;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: compare outputs at the falling edge, predict the next edge's
    // transfers, then return 1 time unit after the rising edge.
    task automatic step();
        op_t o;
        int  ez;
        int  ee;
        bit  xout;
        @(negedge clk);
        if (!rst_n) begin
            sb.delete();
            for (int i = 0; i < NI; i++) exp_max[i] = 0;
            exp_cnt    = 0;
            prev_stall = 1'b0;
            chk("reset_out_valid", int'(ov_a[MI]), 0);
        end else begin
            chk("in_ready_rule", int'(ir_a[MI]), int'(!ov_a[MI] || out_ready));
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("valid_agree_L%0d", l_of(i)), int'(ov_a[i]), int'(ov_a[MI]));
                if (sb.size() == 0) begin
                    chk($sformatf("no_stale_out_L%0d", l_of(i)), int'(ov_a[i]), 0);
                end else if (ov_a[i]) begin
                    o  = sb[0];
                    ez = model_z(o.x, o.y, o.ap, l_of(i));
                    chk($sformatf("z_L%0d", l_of(i)), int'(z_a[i]), ez);
                    chk($sformatf("err_L%0d", l_of(i)), int'(err_a[i]), o.x * o.y - ez);
                end
                if (prev_stall) begin
                    chk($sformatf("hold_valid_L%0d", l_of(i)), int'(ov_a[i]), 1);
                    chk($sformatf("hold_z_L%0d", l_of(i)), int'(z_a[i]), prev_z[i]);
                end
                chk($sformatf("max_err_L%0d", l_of(i)), int'(max_a[i]), exp_max[i]);
                chk($sformatf("approx_cnt_L%0d", l_of(i)), int'(cnt_a[i]), exp_cnt);
            end
            xout = ov_a[MI] && out_ready && (sb.size() > 0);
            if (clr_stats) begin
                for (int i = 0; i < NI; i++) exp_max[i] = 0;
                exp_cnt = 0;
            end else if (xout) begin
                o = sb[0];
                if (o.ap && exp_cnt < 65535) exp_cnt++;
                for (int i = 0; i < NI; i++) begin
                    ee = o.x * o.y - model_z(o.x, o.y, o.ap, l_of(i));
                    if (ee > exp_max[i]) exp_max[i] = ee;
                end
            end
            if (xout) begin
                sb.delete(0);
                out_xfers++;
            end
            if (in_valid && ir_a[MI]) begin
                o.x  = int'(x);
                o.y  = int'(y);
                o.ap = approx;
                sb.push_back(o);
            end
            prev_stall = ov_a[MI] && !out_ready;
            for (int i = 0; i < NI; i++) prev_z[i] = int'(z_a[i]);
        end
        @(posedge clk);
        #1;
    endtask

    // Single operation into an idle pipeline: latency and hand-computed result.
    task automatic run_single(input logic [7:0] xv, input logic [7:0] yv, input logic ap,
                              input int ez, input int ee);
        int lat;
        x = xv; y = yv; approx = ap; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!ov_a[MI] && lat < 10) begin
            step();
            lat++;
        end
        chk("latency", lat, 3);
        chk("lit_z", int'(z_a[MI]), ez);
        chk("lit_err", int'(err_a[MI]), ee);
        step();
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            exp_max[i] = 0;
            prev_z[i]  = 0;
        end
        #2;
        chk("rst_out_valid", int'(ov_a[MI]), 0);
        chk("rst_z", int'(z_a[MI]), 0);
        chk("rst_max_err", int'(max_a[MI]), 0);
        chk("rst_approx_cnt", int'(cnt_a[MI]), 0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_reset", int'(ir_a[MI]), 1);
        step();

        // Hand-computed vectors for W=8, L=4.
        run_single(8'hFF, 8'hFF, 1'b1, 'hF810, 'h05F1);
        run_single(8'hFF, 8'hFF, 1'b0, 'hFE01, 0);
        run_single(8'h0F, 8'h01, 1'b1, 'h0000, 'h000F);
        run_single(8'h10, 8'h10, 1'b1, 'h0100, 0);
        chk("lit_max_err", int'(max_a[MI]), 'h05F1);
        chk("lit_approx_cnt", int'(cnt_a[MI]), 3);

        // Back-to-back stream with alternating mode, then a 5-cycle stall.
        out_xfers = 0;
        for (int i = 0; i < 8; i++) begin
            x = 8'(8'h31 + 8'(i * 29));
            y = 8'(8'hC7 - 8'(i * 17));
            approx = ((i % 2) == 0);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("stall_in_ready", int'(ir_a[MI]), 0);
        for (int i = 0; i < 5; i++) step();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("stream_count", out_xfers, 8);
        chk("alt_approx_cnt", int'(cnt_a[MI]), 7);

        // Clear coinciding with an output transfer.
        x = 8'hFF; y = 8'hFF; approx = 1'b1; in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        step();
        chk("pre_clr_valid", int'(ov_a[MI]), 1);
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        chk("clr_max_err", int'(max_a[MI]), 0);
        chk("clr_approx_cnt", int'(cnt_a[MI]), 0);
        for (int i = 0; i < 4; i++) step();
        chk("post_clr_max_err", int'(max_a[MI]), 'h05F1);

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            x = 8'(8'hA5 + 8'(i)); y = 8'h5A; approx = 1'b1; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(ov_a[MI]), 0);
        chk("midrst_max_err", int'(max_a[MI]), 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // Random traffic, all four L variants checked against the model.
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            x         = 8'($urandom_range(0, 255));
            y         = 8'($urandom_range(0, 255));
            approx    = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            clr_stats = ($urandom_range(0, 99) == 0);
            step();
        end
        in_valid = 1'b0;
        clr_stats = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("drain_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
